// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package fetch_pc_unit_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   // IDLE: nothing outstanding; BUSY: response will be kept;
   // DROP: response will be discarded (a redirect overtook it).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage : fetch_pc_unit_pkg

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC sequencer.
// Owns the fetch PC, keeps at most one request outstanding to instruction
// memory (req/ack), and holds the fetched word in a one-entry buffer for decode.
// Taken branches and jumps redirect fetch, flush younger work and cause any
// in-flight response to be discarded.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   br_valid/br_taken/br_offset/br_pc  branch resolution from execute
//   jmp_valid/jmp_target            jump resolution from execute
//   imem_req/imem_addr              fetch request toward instruction memory
//   imem_ack/imem_rdata             memory response
//   if_valid/if_instr/if_pc         buffered instruction toward decode
//   id_ready                        decode takes the buffer
//   flush                           kill younger instructions (combinational)
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               br_valid,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_offset,
   input  logic [ADDR_W-1:0]  br_pc,
   input  logic               jmp_valid,
   input  logic [ADDR_W-1:0]  jmp_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               id_ready,
   output logic               flush
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                if_valid_d;
   logic                load;
   logic [ADDR_W-1:0]   load_pc;
   logic                req_raw;
   logic                br_redirect;
   logic                redirect;
   logic                buf_free;
   logic [ADDR_W-1:0]   target;

   // Redirect decode; a taken branch wins over a simultaneous jump.
   always_comb begin
      br_redirect = br_valid & br_taken;
      redirect    = br_redirect | jmp_valid;
      target      = br_redirect ? (br_pc + PC_STEP + br_offset)
                                : (jmp_target & ~ADDR_W'(3));
      buf_free    = ~if_valid | id_ready;
      flush       = redirect & rst_n;
   end

   // Next-state, request and buffer-load decisions.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      load      = 1'b0;
      load_pc   = pc_q;
      req_raw   = 1'b0;
      imem_addr = pc_q;

      unique case (state_q)
         IDLE: begin
            req_raw   = buf_free & ~redirect;
            imem_addr = pc_q;
            if (redirect) begin
               pc_d = target;
            end else if (req_raw) begin
               if (imem_ack) begin
                  load = 1'b1;
                  pc_d = pc_q + PC_STEP;
               end else begin
                  addr_d  = pc_q;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            req_raw   = 1'b1;
            imem_addr = addr_q;
            if (imem_ack) begin
               state_d = IDLE;
               if (redirect) begin
                  pc_d = target;
               end else begin
                  load    = 1'b1;
                  load_pc = addr_q;
                  pc_d    = addr_q + PC_STEP;
               end
            end else if (redirect) begin
               pc_d    = target;
               state_d = DROP;
            end
         end
         DROP: begin
            req_raw   = 1'b1;
            imem_addr = addr_q;
            if (redirect) begin
               pc_d = target;
            end
            if (imem_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      imem_req = req_raw & rst_n;

      // Redirect always empties the buffer; otherwise refill beats drain.
      if (redirect) begin
         if_valid_d = 1'b0;
      end else if (load) begin
         if_valid_d = 1'b1;
      end else if (if_valid & id_ready) begin
         if_valid_d = 1'b0;
      end else begin
         if_valid_d = if_valid;
      end
   end

   // State, PC, latched address and instruction buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         if_valid <= if_valid_d;
         if (load) begin
            if_instr <= imem_rdata;
            if_pc    <= load_pc;
         end
      end
   end

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expected values.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_offset;
   logic [31:0] br_pc;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        flush;

   int unsigned n_checks;
   int unsigned n_errors;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .br_valid   (br_valid),
      .br_taken   (br_taken),
      .br_offset  (br_offset),
      .br_pc      (br_pc),
      .jmp_valid  (jmp_valid),
      .jmp_target (jmp_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .id_ready   (id_ready),
      .flush      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      br_valid   = 1'b1;
      br_taken   = 1'b1;
      br_offset  = '0;
      br_pc      = '0;
      jmp_valid  = 1'b0;
      jmp_target = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      id_ready   = 1'b0;
      #2;
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      tick();
      tick();
      br_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);

      // Zero-wait streaming from RESET_PC.
      tick();
      rst_n      = 1'b1;
      id_ready   = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hA000_0000;
      #1;
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      chk("first_if_valid", 32'(if_valid), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         imem_rdata = 32'hA000_0000 + 32'(4 * i);
         #1;
         chk("stream_addr", imem_addr, 32'(4 * i));
         chk("stream_if_pc", if_pc, 32'(4 * (i - 1)));
         chk("stream_if_valid", 32'(if_valid), 32'd1);
      end

      // Decode stalls; a spurious ack with no request must be ignored.
      tick();
      id_ready   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_if_pc", if_pc, 32'h0000_000C);
      tick();
      chk("stall_hold_instr", if_instr, 32'hA000_000C);
      chk("stall_hold_pc", if_pc, 32'h0000_000C);
      chk("stall_hold_req", 32'(imem_req), 32'd0);
      imem_ack = 1'b0;
      id_ready = 1'b1;
      #1;
      chk("unstall_req", 32'(imem_req), 32'd1);
      chk("unstall_addr", imem_addr, 32'h10);
      tick();
      chk("busy_if_valid", 32'(if_valid), 32'd0);
      chk("busy_addr", imem_addr, 32'h10);
      imem_ack   = 1'b1;
      imem_rdata = 32'hA000_0010;

      // Taken branch in IDLE: 0x100 + 4 - 16 = 0xF4.
      tick();
      imem_ack  = 1'b0;
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_pc     = 32'h0000_0100;
      br_offset = 32'hFFFF_FFF0;
      #1;
      chk("late_ack_if_pc", if_pc, 32'h10);
      chk("br_flush", 32'(flush), 32'd1);
      chk("br_req", 32'(imem_req), 32'd0);
      tick();
      br_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      chk("br_if_valid", 32'(if_valid), 32'd0);
      chk("br_target_req", 32'(imem_req), 32'd1);
      chk("br_target_addr", imem_addr, 32'h0000_00F4);

      // Jump while BUSY: the in-flight response is dropped.
      tick();
      jmp_valid  = 1'b1;
      jmp_target = 32'h0000_0300;
      #1;
      chk("busy_jmp_flush", 32'(flush), 32'd1);
      chk("busy_jmp_addr", imem_addr, 32'h0000_00F4);
      tick();
      jmp_valid = 1'b0;
      #1;
      chk("drop1_req", 32'(imem_req), 32'd1);
      chk("drop1_addr", imem_addr, 32'h0000_00F4);
      tick();
      chk("drop2_addr", imem_addr, 32'h0000_00F4);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("drop3_addr", imem_addr, 32'h0000_00F4);
      tick();
      imem_rdata = 32'hB000_0300;
      #1;
      chk("drop_if_valid", 32'(if_valid), 32'd0);
      chk("after_drop_req", 32'(imem_req), 32'd1);
      chk("after_drop_addr", imem_addr, 32'h0000_0300);

      // Branch and jump together: 0x1000 + 4 + 8 = 0x100C wins over 0x2000.
      tick();
      imem_ack   = 1'b0;
      br_valid   = 1'b1;
      br_taken   = 1'b1;
      br_pc      = 32'h0000_1000;
      br_offset  = 32'h0000_0008;
      jmp_valid  = 1'b1;
      jmp_target = 32'h0000_2003;
      #1;
      chk("tgt_if_valid", 32'(if_valid), 32'd1);
      chk("tgt_if_pc", if_pc, 32'h0000_0300);
      chk("tgt_if_instr", if_instr, 32'hB000_0300);
      chk("both_flush", 32'(flush), 32'd1);
      tick();
      br_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      chk("both_addr", imem_addr, 32'h0000_100C);
      chk("both_if_valid", 32'(if_valid), 32'd0);
      chk("jmp_req", 32'(imem_req), 32'd0);
      tick();
      jmp_valid = 1'b0;
      br_valid  = 1'b1;
      br_taken  = 1'b0;
      #1;
      chk("nt_flush", 32'(flush), 32'd0);
      chk("jmp_req_after", 32'(imem_req), 32'd1);
      chk("jmp_addr", imem_addr, 32'h0000_2000);

      // Reset in the middle of an outstanding request.
      tick();
      br_valid = 1'b0;
      #1;
      chk("pre_rst_busy_addr", imem_addr, 32'h0000_2000);
      rst_n     = 1'b0;
      jmp_valid = 1'b1;
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_if_pc", if_pc, 32'd0);
      chk("mid_rst_if_instr", if_instr, 32'd0);
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      jmp_valid = 1'b0;
      imem_ack  = 1'b0;
      rst_n     = 1'b1;
      #1;
      chk("restart_if_valid", 32'(if_valid), 32'd0);
      chk("restart_req", 32'(imem_req), 32'd1);
      chk("restart_addr", imem_addr, 32'h0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hC000_0000;
      tick();
      imem_ack = 1'b0;
      #1;
      chk("restart_load_valid", 32'(if_valid), 32'd1);
      chk("restart_load_pc", if_pc, 32'h0);
      chk("restart_load_instr", if_instr, 32'hC000_0000);
      chk("restart_next_addr", imem_addr, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch PC sequencer that consumes the execute stage's branch resolution (taken flag plus sign-extended, word-shifted offset) and jump requests, and redirects fetch. It owns the architectural fetch PC, issues one outstanding request at a time to instruction memory over a req/ack handshake, and holds the fetched instruction in a one-entry buffer toward decode. On redirect it flushes younger work and discards any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- br_valid  in  1  execute stage resolved a conditional branch this cycle
- br_taken  in  1  branch condition true (qualified by br_valid)
- br_offset  in  32  sign-extended immediate already shifted left 2
- br_pc  in  32  PC of the resolving branch
- jmp_valid  in  1  unconditional jump resolved this cycle
- jmp_target  in  32  absolute jump target; bits [1:0] ignored
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  32  buffered instruction
- if_pc  out  32  PC of buffered instruction
- id_ready  in  1  decode accepts the buffer this cycle
- flush  out  1  kill younger instructions in decode/execute

## Operation
- redirect = (br_valid & br_taken) | jmp_valid; branch has priority if both. Target: branch = br_pc + 4 + br_offset, mod 2^32 (wrap silently); jump = {jmp_target[31:2], 2'b00}.
- flush = redirect & rst_n, combinational, same cycle as redirect.
- Buffer free = !if_valid | id_ready. Drain: if_valid & id_ready clears if_valid unless refilled the same edge.
- States: IDLE (nothing outstanding), BUSY (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE: imem_req = free & !redirect; imem_addr = pc. Issue+ack same cycle -> load buffer, pc += 4, stay IDLE. Issue without ack -> latch addr, BUSY. Redirect -> pc <= target, no issue.
- BUSY: imem_req = 1, imem_addr = latched addr (stable until ack). Ack & !redirect -> load buffer, pc += 4, IDLE. Ack & redirect -> discard, pc <= target, IDLE. Redirect without ack -> pc <= target, DROP.
- DROP: imem_req = 1, same latched addr. Ack -> discard, IDLE. Further redirect -> pc <= newest target, stay DROP.
- Any redirect clears if_valid at the next edge regardless of id_ready or ack.
- Request is never withdrawn before ack; address never changes while outstanding.

## Timing
- Reset (async): state IDLE, pc = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, latched addr = 0; imem_req and flush forced 0 while rst_n low.
- First request in first cycle with rst_n high, addr RESET_PC.
- Latency: ack at cycle n -> if_valid at n+1. Zero-wait memory with id_ready held 1 -> one instruction per cycle.
- Redirect at cycle n -> first request to target at n+1 (from IDLE) or cycle after the dropped ack (from BUSY/DROP).
- Reset asserted mid-request abandons it; a late ack after reset is ignored (state IDLE, no request pending, ack in IDLE without imem_req is ignored).

## Structure
- Shared package: state enum {IDLE, BUSY, DROP}, PC_STEP = 32'd4, INSTR_W = 32.
- Single module; no sub-module needed. Redirect target adder stays inline.

## Test plan
- Reset release, RESET_PC = 0, zero-wait ack, id_ready = 1 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later.
- id_ready = 0 with if_valid = 1 -> imem_req = 0, buffer and pc hold; id_ready = 1 -> request at next PC same cycle.
- Branch br_pc = 0x100, br_offset = 0xFFFF_FFF0, taken, in IDLE -> flush = 1 that cycle, next imem_addr = 0xF4, if_valid = 0.
- Redirect in BUSY with ack 3 cycles later -> DROP, stale data never reaches if_valid, next request to target after the ack.
- br_taken and jmp_valid together, jmp_target = 0x2003 -> branch target used; jump alone -> addr 0x2000.
- rst_n low during BUSY, ack arrives after release -> outputs at reset values, fetch restarts at RESET_PC, stale ack ignored.
